rr_dff_arbiter: RTL and testbench
=================================

Name:
rr_dff_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop register (q) between 4 requesters.
- Each requester raises req[i] and drives its data on d_i. While it holds the grant, its data is captured into q every cycle.
- Grant tenure is bounded by HOLD_MAX cycles, so one requester cannot starve the others.
- Sits between requester logic and the shared storage element in lab datapaths.

Parameters:
- WIDTH, 8, data width of d0..d3 and q.
- HOLD_MAX, 4, maximum consecutive cycles a grantee keeps the grant; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset, sampled on rising edge of clk.
- req  input  4  request lines; req[i] belongs to requester i.
- d0  input  WIDTH  data of requester 0.
- d1  input  WIDTH  data of requester 1.
- d2  input  WIDTH  data of requester 2.
- d3  input  WIDTH  data of requester 3.
- grant  output  4  registered one-hot (or zero) grant.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  registered; 1 when q was loaded on the last edge.
- busy  output  1  combinational OR of grant bits.

Behaviour:
- Internal state:
  - ptr (2 bits): index of the last granted requester.
  - cnt (4 bits): grant tenure counter.
  - g: index of the current grant (one-hot grant register).
- Reset (reset=1 at an edge) overrides all other activity, including mid-grant:
  - grant=4'b0000, q=0, q_valid=0, busy=0.
  - cnt=0, ptr=3, so requester 0 has first priority after reset.
- Keep condition, evaluated at each edge when reset=0: grant is active AND req[g]=1 AND cnt < HOLD_MAX-1.
  - If it holds: grant unchanged, cnt <= cnt+1.
- Otherwise (idle, or release because req[g] dropped or the tenure limit was reached):
  - Scan order is start+1, start+2, start+3, start mod 4, where start = g if grant is active, else ptr.
  - grant <= one-hot of the first index in scan order with req=1, or 0 if none.
  - cnt <= 0; ptr <= new index when a grant is issued, otherwise ptr unchanged.
  - The former grantee is re-granted only if it is the sole requester.
- Switching between requesters costs no idle cycle: grant moves directly from one one-hot value to the next.
- Data path, evaluated at each edge:
  - If grant[i]=1 and req[i]=1: q <= d_i, q_valid <= 1.
  - Otherwise: q holds its value, q_valid <= 0.
- Latency:
  - req rising in idle -> grant asserted at the next edge.
  - First q load one edge after that.
- A requester dropping req while granted:
  - q_valid=0 for exactly one cycle.
  - Then the next grantee's data appears one edge later.
- A re-grant to a sole requester at the tenure limit keeps q_valid=1 continuously.
- Inputs are sampled only at rising edges. Glitches between edges have no effect.
- Implementation: FSM states IDLE (grant=0) and GRANT (grant one-hot), with transitions per the rules above. Expected size is 120-250 lines of RTL.

Test Plan:
- Reset: hold reset=1 with req=4'b1111 for 2 edges -> grant=0, q=0, q_valid=0, busy=0. First edge after reset=0 -> grant=4'b0001.
- Single requester: req=4'b0100, d2=8'hA5 from idle.
  - Edge 1 -> grant=4'b0100.
  - Edge 2 onward -> q=8'hA5, q_valid=1 continuously.
  - At the 4-cycle tenure limit, grant is re-issued to 4'b0100 with cnt=0 and no q_valid gap.
- Full contention: req=4'b1111, d_i=8'h10+i -> grant sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles. q follows 8'h10, 8'h11, 8'h12, 8'h13, each value lagging its grant by one edge.
- Early drop: req=4'b0011. Requester 0 deasserts after 2 granted cycles.
  - Next edge -> grant=4'b0010, q_valid=0 for that cycle.
  - Following edge -> q=d1, q_valid=1.
- Rotation skip: after requester 1 was served (ptr=1), req=4'b1001 -> grant=4'b1000 first (index 3 scanned before 0), then 4'b0001.
- Reset mid-grant: assert reset while grant=4'b0100 with q_valid=1.
  - Next edge -> all outputs 0.
  - After release with req=4'b0101 -> grant=4'b0001 before 4'b0100.

Source files
------------

// File: rtl/rr_dff_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_dff_arbiter
//  Brief    : Four-way round-robin arbiter owning one shared WIDTH-bit
//             register. The current grantee's data is captured every cycle
//             it holds the grant. Tenure is capped at HOLD_MAX cycles.
//  Revision : 1.0  initial release
// ============================================================================
module rr_dff_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4     // legal range 1..16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic [3:0]       grant,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy
);

  // Arbiter states: IDLE means no grant is held, GRANT means grant is one-hot.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Last count value that still allows one more kept cycle. It is held in
  // five bits so that HOLD_MAX=16 (last value 15) and HOLD_MAX=1 (last
  // value 0, so the grant is never kept) are both representable.
  localparam logic [4:0] c_HOLD_LAST = 5'(HOLD_MAX - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       idx_q,   idx_d;    // index of the current grantee
  logic [1:0]       ptr_q,   ptr_d;    // index of the last grantee issued
  logic [3:0]       cnt_q,   cnt_d;    // cycles already kept in this tenure
  logic [WIDTH-1:0] q_q,     q_d;
  logic             q_valid_q, q_valid_d;

  // --------------------------------------------------------------------------
  // Data inputs gathered into an array so the grantee index can select them.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_din [4];

  assign w_din[0] = d0;
  assign w_din[1] = d1;
  assign w_din[2] = d2;
  assign w_din[3] = d3;

  // --------------------------------------------------------------------------
  // Round-robin scan. Candidates are start+1 .. start+4 (mod 4), so the
  // start index itself is looked at last. The former grantee therefore
  // wins again only when nobody else is requesting.
  // --------------------------------------------------------------------------
  logic [1:0] w_start;
  logic [1:0] w_scan_idx [4];
  logic [3:0] w_scan_hit;
  logic [1:0] w_pick;
  logic       w_found;

  assign w_start = (state_q == S_GRANT) ? idx_q : ptr_q;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_scan
      assign w_scan_idx[k] = w_start + 2'(k + 1);
      assign w_scan_hit[k] = req[w_scan_idx[k]];
    end
  endgenerate

  // Choose the first requesting candidate in scan order.
  always_comb begin
    w_found = 1'b0;
    w_pick  = w_start;
    for (int k = 3; k >= 0; k--) begin
      if (w_scan_hit[k]) begin
        w_found = 1'b1;
        w_pick  = w_scan_idx[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Keep condition: the grantee is still requesting and its tenure is below
  // the limit.
  // --------------------------------------------------------------------------
  logic w_keep;

  assign w_keep = (state_q == S_GRANT) && req[idx_q] &&
                  ({1'b0, cnt_q} < c_HOLD_LAST);

  // Next grant, pointer and tenure count.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d = S_GRANT;
          grant_d = 4'b0001 << w_pick;
          idx_d   = w_pick;
          ptr_d   = w_pick;
          cnt_d   = 4'd0;
        end
      end
      S_GRANT: begin
        if (w_keep) begin
          cnt_d = cnt_q + 4'd1;
        end else if (w_found) begin
          // Direct hand-over: no idle cycle between grantees.
          grant_d = 4'b0001 << w_pick;
          idx_d   = w_pick;
          ptr_d   = w_pick;
          cnt_d   = 4'd0;
        end else begin
          state_d = S_IDLE;
          grant_d = 4'b0000;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared register. It loads only while the granted requester still
  // requests, so a dropped request shows up as a one-cycle q_valid gap.
  // --------------------------------------------------------------------------
  logic w_load;

  assign w_load = |(grant_q & req);

  // Capture the grantee's data, or hold q and flag it as not freshly loaded.
  always_comb begin
    q_d       = q_q;
    q_valid_d = 1'b0;
    if (w_load) begin
      q_d       = w_din[idx_q];
      q_valid_d = 1'b1;
    end
  end

  // State registers. Reset overrides everything and leaves requester 0
  // with first priority (ptr=3, so the scan starts at 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 4'b0000;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd3;
      cnt_q     <= 4'd0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign grant   = grant_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = |grant_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_dff_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_dff_arbiter
//  Brief    : Self-checking bench for rr_dff_arbiter. A behavioural model
//             (grantee index, tenure count, last-served pointer) predicts
//             every output after each edge. Directed scenarios add literal
//             expectations, and a randomized phase follows them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_dff_arbiter;

  localparam int W    = 8;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [W-1:0] d0, d1, d2, d3;
  logic [3:0]   grant;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;

  rr_dff_arbiter #(.WIDTH(W), .HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .grant   (grant),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: grantee index (-1 = none), tenure, last served.
  int           m_g   = -1;
  int           m_cnt = 0;
  int           m_ptr = 3;
  logic [W-1:0] m_q   = '0;
  logic         m_qv  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [3:0] r, input logic [W-1:0] dd [4]);
    int start;
    int ng;
    if (rst) begin
      m_g = -1; m_cnt = 0; m_ptr = 3; m_q = '0; m_qv = 1'b0;
      return;
    end
    // Data path uses the grant held before this edge.
    if (m_g >= 0 && r[m_g]) begin
      m_q  = dd[m_g];
      m_qv = 1'b1;
    end else begin
      m_qv = 1'b0;
    end
    if (m_g >= 0 && r[m_g] && m_cnt < HOLD - 1) begin
      m_cnt = m_cnt + 1;
    end else begin
      start = (m_g >= 0) ? m_g : m_ptr;
      ng    = -1;
      for (int k = 1; k <= 4; k++) begin
        if (ng < 0 && r[(start + k) % 4]) ng = (start + k) % 4;
      end
      m_g   = ng;
      m_cnt = 0;
      if (ng >= 0) m_ptr = ng;
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    eg = (m_g < 0) ? 4'b0000 : (4'b0001 << m_g);
    chk("model_grant",   {28'd0, grant},   {28'd0, eg});
    chk("model_q",       {24'd0, q},       {24'd0, m_q});
    chk("model_q_valid", {31'd0, q_valid}, {31'd0, m_qv});
    chk("model_busy",    {31'd0, busy},    {31'd0, (m_g >= 0)});
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic step(input logic rst, input logic [3:0] r,
                      input logic [W-1:0] a0, input logic [W-1:0] a1,
                      input logic [W-1:0] a2, input logic [W-1:0] a3);
    logic [W-1:0] dd [4];
    reset = rst; req = r; d0 = a0; d1 = a1; d2 = a2; d3 = a3;
    dd[0] = a0; dd[1] = a1; dd[2] = a2; dd[3] = a3;
    @(posedge clk);
    model_edge(rst, r, dd);
    #1;
    check_model();
  endtask

  initial begin
    logic [3:0] r;

    reset = 1'b1; req = 4'b0000; d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    // Reset with all requests raised.
    step(1'b1, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    step(1'b1, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    chk("rst_grant",   {28'd0, grant},   32'h0);
    chk("rst_q",       {24'd0, q},       32'h0);
    chk("rst_q_valid", {31'd0, q_valid}, 32'h0);
    chk("rst_busy",    {31'd0, busy},    32'h0);
    step(1'b0, 4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    chk("rst_first_grant", {28'd0, grant}, 32'h1);

    // Single requester: continuous q_valid across the tenure re-issue.
    step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
    chk("single_grant", {28'd0, grant}, 32'h4);
    for (int n = 2; n <= 9; n++) begin
      step(1'b0, 4'b0100, 8'h00, 8'h00, 8'hA5, 8'h00);
      chk("single_grant_hold", {28'd0, grant},   32'h4);
      chk("single_q",          {24'd0, q},       32'hA5);
      chk("single_q_valid",    {31'd0, q_valid}, 32'h1);
    end

    // Full contention: each requester holds 4 cycles, q lags by one edge.
    step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int n = 1; n <= 17; n++) begin
      step(1'b0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
      chk("full_grant", {28'd0, grant}, 32'(1 << (((n - 1) / 4) % 4)));
      if (n >= 2) begin
        chk("full_q",       {24'd0, q},       32'h10 + 32'(((n - 2) / 4) % 4));
        chk("full_q_valid", {31'd0, q_valid}, 32'h1);
      end
    end

    // Early drop of requester 0 after two granted cycles.
    step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 4'b0011, 8'h3C, 8'hC3, 8'h00, 8'h00);
    chk("drop_grant0", {28'd0, grant}, 32'h1);
    step(1'b0, 4'b0011, 8'h3C, 8'hC3, 8'h00, 8'h00);
    step(1'b0, 4'b0010, 8'h3C, 8'hC3, 8'h00, 8'h00);
    chk("drop_grant1", {28'd0, grant},   32'h2);
    chk("drop_gap",    {31'd0, q_valid}, 32'h0);
    chk("drop_q_hold", {24'd0, q},       32'h3C);
    step(1'b0, 4'b0010, 8'h3C, 8'hC3, 8'h00, 8'h00);
    chk("drop_q1",       {24'd0, q},       32'hC3);
    chk("drop_q_valid1", {31'd0, q_valid}, 32'h1);

    // Rotation skip: last served is 1, so 3 is scanned before 0.
    step(1'b0, 4'b1001, 8'h5A, 8'hC3, 8'h00, 8'h77);
    chk("rot_grant3", {28'd0, grant}, 32'h8);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 4'b1001, 8'h5A, 8'hC3, 8'h00, 8'h77);
      chk("rot_hold3", {28'd0, grant}, 32'h8);
      chk("rot_q3",    {24'd0, q},     32'h77);
    end
    step(1'b0, 4'b1001, 8'h5A, 8'hC3, 8'h00, 8'h77);
    chk("rot_grant0", {28'd0, grant}, 32'h1);

    // Reset in the middle of a grant.
    step(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    step(1'b0, 4'b0100, 8'h00, 8'h00, 8'hE1, 8'h00);
    step(1'b0, 4'b0100, 8'h00, 8'h00, 8'hE1, 8'h00);
    chk("mid_q_valid", {31'd0, q_valid}, 32'h1);
    chk("mid_q",       {24'd0, q},       32'hE1);
    step(1'b1, 4'b0100, 8'h00, 8'h00, 8'hE1, 8'h00);
    chk("mid_rst_grant",   {28'd0, grant},   32'h0);
    chk("mid_rst_q",       {24'd0, q},       32'h0);
    chk("mid_rst_q_valid", {31'd0, q_valid}, 32'h0);
    chk("mid_rst_busy",    {31'd0, busy},    32'h0);
    step(1'b0, 4'b0101, 8'h0F, 8'h00, 8'hE1, 8'h00);
    chk("mid_after_grant0", {28'd0, grant}, 32'h1);
    for (int n = 0; n < 3; n++) step(1'b0, 4'b0101, 8'h0F, 8'h00, 8'hE1, 8'h00);
    step(1'b0, 4'b0101, 8'h0F, 8'h00, 8'hE1, 8'h00);
    chk("mid_after_grant2", {28'd0, grant}, 32'h4);

    // Randomized traffic with sticky requests and occasional resets.
    r = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3, 0) == 0) r = 4'($urandom_range(15, 0));
      step(($urandom_range(63, 0) == 0), r,
           8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
